// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   reg_addr_t - register address, wide enough for any supported ADDR_WIDTH
//   fwd_sel_t  - forwarding select, wide enough for any DEPTH up to 8
//   sb_entry_t - one scoreboard slot {valid, rd, load, rs1, rs2}
//   FWD_RF     - forwarding select meaning "use the register file"
package hazard_pkg;
   localparam int REG_AW_MAX = 8;
   localparam int FWD_W = 3;
   typedef logic [REG_AW_MAX-1:0] reg_addr_t;
   typedef logic [FWD_W-1:0] fwd_sel_t;
   localparam fwd_sel_t FWD_RF = '0;
   typedef struct packed {
      logic      valid;
      reg_addr_t rd;
      logic      load;
      reg_addr_t rs1;
      reg_addr_t rs2;
   } sb_entry_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, clears the count
//   inc_i  - count one event this cycle
//   cnt_o  - current count
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + WIDTH'(1) : cnt_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based forwarding, load-use stall and flush control.
//   clk_i, rst_ni                 - clock, asynchronous active-low reset
//   valid_d_i, rs1/rs2/rd_d_i     - decode-stage instruction and its registers
//   reg_write_d_i, load_d_i       - decode instruction writes rd / is a load
//   pc_src_e_i                    - taken branch or jump resolved in execute
//   stall_f_o, stall_d_o          - hold PC and fetch/decode register
//   flush_d_o, flush_e_o          - clear fetch/decode and decode/execute registers
//   fwd_a_o, fwd_b_o              - execute operand select, 0 = register file, k = stage k
//   stall_cnt_o, flush_cnt_o      - saturating stall / flush event counters
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     valid_d_i,
   input  logic [ADDR_WIDTH-1:0]    rs1_d_i,
   input  logic [ADDR_WIDTH-1:0]    rs2_d_i,
   input  logic [ADDR_WIDTH-1:0]    rd_d_i,
   input  logic                     reg_write_d_i,
   input  logic                     load_d_i,
   input  logic                     pc_src_e_i,
   output logic                     stall_f_o,
   output logic                     stall_d_o,
   output logic                     flush_d_o,
   output logic                     flush_e_o,
   output logic [$clog2(DEPTH)-1:0] fwd_a_o,
   output logic [$clog2(DEPTH)-1:0] fwd_b_o,
   output logic [CNT_WIDTH-1:0]     stall_cnt_o,
   output logic [CNT_WIDTH-1:0]     flush_cnt_o
);
   localparam int FW = $clog2(DEPTH);
   sb_entry_t        sb_q [DEPTH];
   sb_entry_t        sb_d [DEPTH];
   sb_entry_t        dec_e;
   logic [DEPTH-1:0] hit_a, hit_b, lu;
   fwd_sel_t         sel_a, sel_b;
   reg_addr_t        rs1_d, rs2_d;
   logic             stall, flush, advance;
   assign rs1_d = reg_addr_t'(rs1_d_i);
   assign rs2_d = reg_addr_t'(rs2_d_i);
   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      // Stage 0 is execute itself; a load becomes forwardable at LOAD_STAGE
      // and still blocks a decode consumer while it cannot arrive in time.
      localparam bit IS_EX     = (s == 0);
      localparam bit LOAD_FWD  = (s >= LOAD_STAGE);
      localparam bit LOAD_WAIT = (s + 1 < LOAD_STAGE);
      logic elig;
      assign elig     = !IS_EX && sb_q[s].valid && (!sb_q[s].load || LOAD_FWD);
      assign hit_a[s] = elig && sb_q[0].rs1 != '0 && sb_q[s].rd == sb_q[0].rs1;
      assign hit_b[s] = elig && sb_q[0].rs2 != '0 && sb_q[s].rd == sb_q[0].rs2;
      assign lu[s]    = LOAD_WAIT && sb_q[s].valid && sb_q[s].load &&
                        ((rs1_d != '0 && sb_q[s].rd == rs1_d) ||
                         (rs2_d != '0 && sb_q[s].rd == rs2_d));
   end
   // Scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      sel_a = FWD_RF;
      sel_b = FWD_RF;
      for (int k = DEPTH - 1; k > 0; k--) begin
         sel_a = hit_a[k] ? fwd_sel_t'(k) : sel_a;
         sel_b = hit_b[k] ? fwd_sel_t'(k) : sel_b;
      end
   end
   // A flush discards the decode instruction, so it also cancels its stall.
   assign flush   = rst_ni && pc_src_e_i;
   assign stall   = rst_ni && valid_d_i && (|lu) && !pc_src_e_i;
   assign advance = valid_d_i && !stall && !flush;
   always_comb begin
      dec_e = sb_entry_t'{valid: reg_write_d_i && rd_d_i != '0, rd: reg_addr_t'(rd_d_i),
                          load: load_d_i, rs1: rs1_d, rs2: rs2_d};
      sb_d[0] = advance ? dec_e : '0;
      for (int k = 1; k < DEPTH; k++) sb_d[k] = sb_q[k-1];
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) sb_q <= '{default: '0};
      else sb_q <= sb_d;
   assign stall_f_o = stall;
   assign stall_d_o = stall;
   assign flush_d_o = flush;
   assign flush_e_o = flush || stall;
   assign fwd_a_o   = FW'(sel_a);
   assign fwd_b_o   = FW'(sel_b);
   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (stall),
      .cnt_o (stall_cnt_o)
   );
   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (flush),
      .cnt_o (flush_cnt_o)
   );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of forwarding, stalls, flushes, reset and counters.
module tb_pipe_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst_ni;
   logic       valid, rw, ld, pc;
   logic [4:0] rs1, rs2, rd;
   logic       a_sf, a_sd, a_fd, a_fe;
   logic [1:0] a_fa, a_fb;
   logic [15:0] a_sc, a_fc;
   logic       d5_sf, d5_sd, d5_fd, d5_fe;
   logic [2:0] d5_fa, d5_fb;
   logic [15:0] d5_sc, d5_fc;
   logic       c4_sf, c4_sd, c4_fd, c4_fe;
   logic [1:0] c4_fa, c4_fb;
   logic [3:0] c4_sc, c4_fc;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   pipe_hazard_ctrl u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .valid_d_i(valid), .rs1_d_i(rs1), .rs2_d_i(rs2),
      .rd_d_i(rd), .reg_write_d_i(rw), .load_d_i(ld), .pc_src_e_i(pc),
      .stall_f_o(a_sf), .stall_d_o(a_sd), .flush_d_o(a_fd), .flush_e_o(a_fe),
      .fwd_a_o(a_fa), .fwd_b_o(a_fb), .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
   );
   pipe_hazard_ctrl #(.DEPTH(5), .LOAD_STAGE(3)) u_d5 (
      .clk_i(clk), .rst_ni(rst_ni), .valid_d_i(valid), .rs1_d_i(rs1), .rs2_d_i(rs2),
      .rd_d_i(rd), .reg_write_d_i(rw), .load_d_i(ld), .pc_src_e_i(pc),
      .stall_f_o(d5_sf), .stall_d_o(d5_sd), .flush_d_o(d5_fd), .flush_e_o(d5_fe),
      .fwd_a_o(d5_fa), .fwd_b_o(d5_fb), .stall_cnt_o(d5_sc), .flush_cnt_o(d5_fc)
   );
   pipe_hazard_ctrl #(.CNT_WIDTH(4)) u_c4 (
      .clk_i(clk), .rst_ni(rst_ni), .valid_d_i(valid), .rs1_d_i(rs1), .rs2_d_i(rs2),
      .rd_d_i(rd), .reg_write_d_i(rw), .load_d_i(ld), .pc_src_e_i(pc),
      .stall_f_o(c4_sf), .stall_d_o(c4_sd), .flush_d_o(c4_fd), .flush_e_o(c4_fe),
      .fwd_a_o(c4_fa), .fwd_b_o(c4_fb), .stall_cnt_o(c4_sc), .flush_cnt_o(c4_fc)
   );
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic issue(input bit v, input int r1, input int r2, input int d,
                        input bit w, input bit l, input bit p);
      valid = v;
      rs1 = 5'(r1);
      rs2 = 5'(r2);
      rd = 5'(d);
      rw = w;
      ld = l;
      pc = p;
      #1;
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      issue(0, 0, 0, 0, 0, 0, 0);
      repeat (n) tick();
   endtask
   task automatic all_zero(input string tag);
      chk({tag, "_a"}, int'({a_sf, a_sd, a_fd, a_fe, a_fa, a_fb}), 0);
      chk({tag, "_a_cnt"}, int'({a_sc, a_fc}), 0);
      chk({tag, "_d5"}, int'({d5_sf, d5_sd, d5_fd, d5_fe, d5_fa, d5_fb}), 0);
      chk({tag, "_d5_cnt"}, int'({d5_sc, d5_fc}), 0);
      chk({tag, "_c4"}, int'({c4_sf, c4_sd, c4_fd, c4_fe, c4_fa, c4_fb, c4_sc, c4_fc}), 0);
   endtask
   initial begin
      rst_ni = 1'b0;
      issue(1, 7, 7, 8, 1, 1, 1);
      tick();
      all_zero("in_reset");
      issue(0, 0, 0, 0, 0, 0, 0);
      rst_ni = 1'b1;
      #1;
      all_zero("after_reset");
      // add x5,x1,x2 ; sub x6,x5,x3
      issue(1, 1, 2, 5, 1, 0, 0); tick();
      issue(1, 5, 3, 6, 1, 0, 0);
      chk("fwd1_nostall", a_sf, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0);
      chk("fwd1_a", a_fa, 1);
      chk("fwd1_b", a_fb, 0);
      idle(3);
      // add x5 ; unrelated ; sub x6,x5,x3
      issue(1, 1, 2, 5, 1, 0, 0); tick();
      issue(1, 11, 12, 10, 1, 0, 0); tick();
      issue(1, 5, 3, 6, 1, 0, 0);
      chk("fwd2_nostall", a_sf, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0);
      chk("fwd2_a", a_fa, 2);
      idle(3);
      // lw x7 ; add x8,x7,x7
      issue(1, 1, 0, 7, 1, 1, 0); tick();
      issue(1, 7, 7, 8, 1, 0, 0);
      chk("lu_stall_f", a_sf, 1);
      chk("lu_stall_d", a_sd, 1);
      chk("lu_flush_e", a_fe, 1);
      chk("lu_flush_d", a_fd, 0);
      tick();
      chk("lu_release", a_sf, 0);
      chk("lu_release_fe", a_fe, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0);
      chk("lu_fwd_a", a_fa, 2);
      chk("lu_fwd_b", a_fb, 2);
      chk("lu_stall_cnt", a_sc, 1);
      idle(3);
      // lw x0 ; add x3,x0,x0
      issue(1, 1, 0, 0, 1, 1, 0); tick();
      issue(1, 0, 0, 3, 1, 0, 0);
      chk("x0_nostall", a_sf, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0);
      chk("x0_fwd_a", a_fa, 0);
      chk("x0_fwd_b", a_fb, 0);
      idle(3);
      // two writes to x9, then a use
      issue(1, 1, 2, 9, 1, 0, 0); tick();
      issue(1, 3, 4, 9, 1, 0, 0); tick();
      issue(1, 9, 0, 10, 1, 0, 0); tick();
      issue(0, 0, 0, 0, 0, 0, 0);
      chk("young_fwd_a", a_fa, 1);
      idle(3);
      // branch flush discards add x13; later use of x13 must not forward
      issue(1, 1, 2, 12, 1, 0, 0); tick();
      issue(1, 12, 0, 13, 1, 0, 1);
      chk("flush_d", a_fd, 1);
      chk("flush_e", a_fe, 1);
      chk("flush_nostall", a_sd, 0);
      tick();
      issue(1, 13, 0, 14, 1, 0, 0);
      chk("flush_one_cycle", a_fd, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0);
      chk("flush_bubble_fwd", a_fa, 0);
      chk("flush_cnt", a_fc, 1);
      idle(3);
      // load-use and branch in the same cycle
      issue(1, 1, 0, 7, 1, 1, 0); tick();
      issue(1, 7, 0, 8, 1, 0, 1);
      chk("coll_flush_d", a_fd, 1);
      chk("coll_flush_e", a_fe, 1);
      chk("coll_stall_f", a_sf, 0);
      chk("coll_stall_d", a_sd, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0);
      chk("coll_stall_cnt", a_sc, 1);
      chk("coll_flush_cnt", a_fc, 2);
      idle(3);
      // reset in the middle of a load-use stall
      issue(1, 1, 0, 7, 1, 1, 0); tick();
      issue(1, 7, 7, 8, 1, 0, 0);
      chk("rs_stall_pre", a_sf, 1);
      rst_ni = 1'b0;
      #1;
      chk("rs_stall_f", a_sf, 0);
      chk("rs_flush_e", a_fe, 0);
      chk("rs_stall_cnt", a_sc, 0);
      chk("rs_flush_cnt", a_fc, 0);
      tick();
      rst_ni = 1'b1;
      #1;
      chk("rs_after_stall", a_sf, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0);
      chk("rs_sb_empty_fwd", a_fa, 0);
      idle(6);
      // DEPTH=5, LOAD_STAGE=3: load then dependent use stalls two cycles
      issue(1, 1, 0, 7, 1, 1, 0); tick();
      issue(1, 7, 7, 8, 1, 0, 0);
      chk("d5_stall0", d5_sf, 1);
      tick();
      chk("d5_stall1", d5_sf, 1);
      tick();
      chk("d5_stall2", d5_sf, 0);
      tick();
      issue(0, 0, 0, 0, 0, 0, 0);
      chk("d5_fwd_a", d5_fa, 3);
      chk("d5_fwd_b", d5_fb, 3);
      chk("d5_stall_cnt", d5_sc, 2);
      idle(6);
      // 20 flush cycles: 4-bit counter saturates, 16-bit one counts on
      issue(0, 0, 0, 0, 0, 0, 1);
      repeat (20) tick();
      issue(0, 0, 0, 0, 0, 0, 0);
      chk("c4_sat", c4_fc, 15);
      chk("def_flush_cnt", a_fc, 20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined RV32I core. It tracks every in-flight register write from execute through writeback in an internal scoreboard, and generates operand-forwarding selects for the execute stage. It also generates load-use stalls for fetch/decode and branch/jump flushes. Depth and load latency are parameters, so the same block serves the current 5-stage pipeline and deeper variants. It sits beside the pipeline registers and drives their enable/clear inputs and the execute-stage operand muxes.

## Interface
- `ADDR_WIDTH`, 5: register address width.
- `DEPTH`, 3: tracked stages from execute (index 0) to writeback (index DEPTH-1); legal values 2–8.
- `LOAD_STAGE`, 2: first stage index at which load data is forwardable; legal range 1..DEPTH-1.
- `CNT_WIDTH`, 16: width of the performance counters.
- `clk_i` in 1: clock. One clock only; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `valid_d_i` in 1: the decode stage holds a real instruction.
- `rs1_d_i`, `rs2_d_i` in ADDR_WIDTH: decode source registers.
- `rd_d_i` in ADDR_WIDTH: decode destination register.
- `reg_write_d_i` in 1: decode instruction writes rd.
- `load_d_i` in 1: decode instruction is a load (result_src = 01).
- `pc_src_e_i` in 1: taken branch or jump resolved in execute.
- `stall_f_o`, `stall_d_o` out 1: hold the PC and fetch/decode register.
- `flush_d_o`, `flush_e_o` out 1: clear the fetch/decode and decode/execute registers.
- `fwd_a_o`, `fwd_b_o` out `$clog2(DEPTH)`: execute operand select. 0 = register file; k = result of stage k.
- `stall_cnt_o`, `flush_cnt_o` out CNT_WIDTH: saturating event counters.

## Operation
- **Scoreboard:** DEPTH entries, each holding {valid, rd, load}. Slot 0 additionally holds rs1/rs2 of the instruction in execute.
- **Advance:** every cycle, entry k moves to entry k+1. The entry leaving DEPTH-1 retires.
- **Slot 0 load:**
  - loads the decode fields when decode advances normally;
  - loads a bubble (valid=0) when stalling or flushing.
- **Entry validity:** an entry is valid only when valid_d_i and reg_write_d_i were set and rd ≠ 0. Register x0 never matches any source.
- **Forwarding:**
  - For each execute source with non-zero address, fwd = the smallest k in 1..DEPTH-1 whose entry is valid with matching rd. The youngest producer wins.
  - A load entry is eligible only when k ≥ LOAD_STAGE.
  - No eligible match gives 0.
- **Load-use stall:**
  - Condition: valid_d_i, and a non-zero decode source matches valid load entry j with j+1 < LOAD_STAGE.
  - Effect: stall_f_o = stall_d_o = 1 and flush_e_o = 1. Fetch and decode hold; a bubble enters execute.
- **Flush:**
  - pc_src_e_i = 1 gives flush_d_o = flush_e_o = 1, with no stall.
  - Flush has priority over stall in the same cycle; the stall is dropped because the decode instruction is discarded.
- **Register file:** write-first, so a decode read in the same cycle as a writeback retirement sees the new value. No decode-side bypass is needed.
- **Counters:**
  - stall_cnt increments in each cycle a load-use stall is asserted.
  - flush_cnt increments in each cycle pc_src_e_i is asserted.
  - Both saturate at all-ones.

## Timing
- **Combinational outputs:** stall, flush and fwd outputs are combinational from the inputs and current state, valid in the same cycle.
- **Registered outputs:** only the scoreboard and counters are registered.
- **Stall length:** a load-use stall lasts LOAD_STAGE-1-j cycles. It is 1 cycle for the defaults (load directly ahead); the condition re-evaluates each cycle.
- **Flush length:** a flush lasts exactly the cycle pc_src_e_i is high. In the next cycle, slot 0 is a bubble and decode holds the target-path instruction.
- **Reset:** assertion immediately clears all entries and counters. While rst_ni = 0 and one cycle after, all outputs are 0 (stall/flush low, fwd 0, counters 0). Reset mid-stall drops the stall at once.

## Structure
- **Shared package `hazard_pkg`:**
  - `sb_entry_t` struct {valid, rd, load, rs1, rs2};
  - `fwd_sel_t` typedef;
  - constant `FWD_RF` = 0.
- **Sub-module `sat_counter`:** one sub-module (parameter WIDTH, inputs inc_i, clk_i, rst_ni), instantiated twice for the counters.
- **Priority search:** the forwarding search is a generate loop over stages in the top.

## Test plan
- **Forwarding:** `add x5,x1,x2` followed by `sub x6,x5,x3` → in the sub's execute cycle fwd_a_o = 1, no stall. With one unrelated instruction between them, fwd_a_o = 2.
- **Load-use:** `lw x7,0(x1)` followed by `add x8,x7,x7` → stall_f/stall_d/flush_e high for exactly 1 cycle, then fwd_a_o = fwd_b_o = 2, stall_cnt = 1.
- **x0 and youngest producer:** writes to x0 followed by use of x0 → fwd 0, no stall. Two consecutive writes to x9 then a use → fwd selects stage 1.
- **Branch flush:** pc_src_e_i pulsed for 1 cycle → flush_d and flush_e high that cycle. Next cycle slot 0 is invalid, so a following use of the flushed rd forwards 0; flush_cnt = 1.
- **Stall/flush collision:** load-use condition and pc_src_e_i in the same cycle → flush high, stalls low, stall_cnt unchanged.
- **Reset and parameters:**
  - rst_ni pulsed low mid-stall → outputs 0 immediately, scoreboard empty.
  - DEPTH=5, LOAD_STAGE=3 build: load followed by dependent use → 2-cycle stall.
  - Counter with CNT_WIDTH=4 saturates at 15.
